// File: rtl/hazard_pkg.sv
// Shared defaults, width derivation and forwarding-select encodings for the
// RAW hazard scoreboard.
package hazard_pkg;

    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned NPORT_DEF = 2;
    localparam int unsigned DEPTH_DEF = 3;

    // Width needed to hold a stage index 0..depth.
    function automatic int unsigned lw_of(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned LW_DEF = $clog2(DEPTH_DEF + 1);

    localparam int unsigned FWD_RF  = 0;
    localparam int unsigned FWD_EXE = 1;
    localparam int unsigned FWD_MEM = 2;
    localparam int unsigned FWD_WB  = 3;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: tracks how far the newest producer of a register has
// travelled down the pipeline and when its result becomes forwardable.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned LW    = lw_of(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [LW-1:0] lat_i,
    output logic          valid_o,
    output logic [LW-1:0] age_o,
    output logic [LW-1:0] lat_o
);

    localparam logic [LW-1:0] AGE_MAX = LW'(DEPTH);

    logic          valid_q, valid_d;
    logic [LW-1:0] age_q, age_d;
    logic [LW-1:0] lat_q, lat_d;

    // A new producer overrides ageing of the previous one (WAW).
    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        lat_d   = lat_q;
        if (load_i) begin
            valid_d = 1'b1;
            age_d   = LW'(1);
            lat_d   = lat_i;
        end else if (valid_q) begin
            if (age_q == AGE_MAX) begin
                valid_d = 1'b0;
                age_d   = '0;
            end else begin
                age_d   = age_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            age_q   <= '0;
            lat_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            lat_q   <= lat_d;
        end
    end

    assign valid_o = valid_q;
    assign age_o   = age_q;
    assign lat_o   = lat_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline RAW hazard scoreboard: decides stall vs. issue for the
// instruction in ID and selects the forwarding source for each operand.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int unsigned AW    = AW_DEF,
    parameter  int unsigned NPORT = NPORT_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned LW    = lw_of(DEPTH)
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  issue_valid,
    input  logic [NPORT*AW-1:0]   issue_rs,
    input  logic [NPORT-1:0]      issue_rs_used,
    input  logic                  issue_wreg,
    input  logic [AW-1:0]         issue_rn,
    input  logic [LW-1:0]         issue_lat,
    input  logic                  flush,
    output logic                  stall,
    output logic                  issue_fire,
    output logic [NPORT*LW-1:0]   fwd_sel,
    output logic [15:0]           stall_cnt
);

    localparam int unsigned   NREG    = 2**AW;
    localparam logic [LW-1:0] AGE_MAX = LW'(DEPTH);

    logic          ent_valid [NREG];
    logic [LW-1:0] ent_age   [NREG];
    logic [LW-1:0] ent_lat   [NREG];

    logic [LW-1:0]       lat_eff;
    logic                wr_en;
    logic [NPORT-1:0]    haz;
    logic [NPORT*LW-1:0] fwd_raw;
    logic [AW-1:0]       rs_cur;
    logic                hit;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    // r0 is hardwired: never tracked, never forwarded.
    assign ent_valid[0] = 1'b0;
    assign ent_age[0]   = '0;
    assign ent_lat[0]   = '0;

    always_comb begin
        lat_eff = issue_lat;
        if (issue_lat == '0) begin
            lat_eff = LW'(1);
        end else if (issue_lat > AGE_MAX) begin
            lat_eff = AGE_MAX;
        end
    end

    assign wr_en = issue_fire & issue_wreg & (issue_rn != '0);

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        sb_entry #(
            .DEPTH (DEPTH),
            .LW    (LW)
        ) u_ent (
            .clk_i   (Clock),
            .rst_ni  (Resetn),
            .load_i  (wr_en && (issue_rn == AW'(r))),
            .lat_i   (lat_eff),
            .valid_o (ent_valid[r]),
            .age_o   (ent_age[r]),
            .lat_o   (ent_lat[r])
        );
    end

    // Hazards are judged against current entries, before this issue's own write.
    always_comb begin
        haz     = '0;
        fwd_raw = '0;
        rs_cur  = '0;
        hit     = 1'b0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            rs_cur = issue_rs[p*AW +: AW];
            hit    = issue_rs_used[p] && (rs_cur != '0) && ent_valid[rs_cur];
            if (hit && (ent_age[rs_cur] < ent_lat[rs_cur])) begin
                haz[p] = 1'b1;
            end else if (hit) begin
                fwd_raw[p*LW +: LW] = ent_age[rs_cur];
            end
        end
    end

    assign stall      = Resetn & issue_valid & ~flush & (|haz);
    assign issue_fire = Resetn & issue_valid & ~flush & ~(|haz);
    assign fwd_sel    = Resetn ? fwd_raw : {(NPORT*LW){1'b0}};

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// randomized traffic against a timestamp-based reference model.
module tb_hazard_scoreboard;

    localparam int AW    = 5;
    localparam int NPORT = 2;
    localparam int DEPTH = 3;
    localparam int LW    = 2;

    logic                Clock = 1'b0;
    logic                Resetn;
    logic                issue_valid;
    logic [NPORT*AW-1:0] issue_rs;
    logic [NPORT-1:0]    issue_rs_used;
    logic                issue_wreg;
    logic [AW-1:0]       issue_rn;
    logic [LW-1:0]       issue_lat;
    logic                flush;
    logic                stall;
    logic                issue_fire;
    logic [NPORT*LW-1:0] fwd_sel;
    logic [15:0]         stall_cnt;

    always #5 Clock = ~Clock;

    hazard_scoreboard #(
        .AW    (AW),
        .NPORT (NPORT),
        .DEPTH (DEPTH)
    ) dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rs_used (issue_rs_used),
        .issue_wreg    (issue_wreg),
        .issue_rn      (issue_rn),
        .issue_lat     (issue_lat),
        .flush         (flush),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .fwd_sel       (fwd_sel),
        .stall_cnt     (stall_cnt)
    );

    int cmp_n  = 0;
    int fail_n = 0;
    int cyc    = 0;

    // Reference model: remember the cycle each register's newest producer issued.
    int prod_cyc [32];
    int prod_lat [32];
    int scnt;
    logic    m_stall, m_fire;
    logic [LW-1:0] m_fwd [NPORT];

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            prod_cyc[r] = -100;
            prod_lat[r] = 1;
        end
    endtask

    task automatic model_eval();
        logic any;
        int   rs, a;
        any = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            m_fwd[p] = '0;
            rs = int'(issue_rs[p*AW +: AW]);
            a  = cyc - prod_cyc[rs];
            if (Resetn && issue_rs_used[p] && rs != 0 && a >= 1 && a <= DEPTH) begin
                if (a < prod_lat[rs]) any = 1'b1;
                else m_fwd[p] = LW'(a);
            end
        end
        m_stall = Resetn && issue_valid && !flush && any;
        m_fire  = Resetn && issue_valid && !flush && !any;
    endtask

    task automatic advance();
        int l;
        model_eval();
        if (!Resetn) begin
            model_clear();
            scnt = 0;
        end else begin
            if (m_fire && issue_wreg && issue_rn != 0) begin
                l = int'(issue_lat);
                if (l < 1) l = 1;
                if (l > DEPTH) l = DEPTH;
                prod_cyc[issue_rn] = cyc;
                prod_lat[issue_rn] = l;
            end
            if (m_stall && scnt < 65535) scnt++;
        end
        @(posedge Clock);
        cyc++;
        @(negedge Clock);
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                         input logic [1:0] used, input logic w, input logic [AW-1:0] rn,
                         input logic [LW-1:0] lat, input logic fl);
        issue_valid   = v;
        issue_rs      = {rs1, rs0};
        issue_rs_used = used;
        issue_wreg    = w;
        issue_rn      = rn;
        issue_lat     = lat;
        flush         = fl;
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        advance();
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        drive(1, 5, 5, 2'b11, 1, 5, 2, 0);
        cmp_n++; if (stall !== 1'b0) begin fail_n++; $display("FAIL reset_stall: got %b want 0", stall); end
        cmp_n++; if (issue_fire !== 1'b0) begin fail_n++; $display("FAIL reset_fire: got %b want 0", issue_fire); end
        cmp_n++; if (fwd_sel !== '0) begin fail_n++; $display("FAIL reset_fwd: got %h want 0", fwd_sel); end
        advance();
        advance();
        cmp_n++; if (stall_cnt !== 16'd0) begin fail_n++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        Resetn = 1'b1;
        drive(1, 5, 5, 2'b11, 0, 0, 1, 0);
        cmp_n++; if (stall !== 1'b0 || issue_fire !== 1'b1) begin fail_n++; $display("FAIL reset_release: got stall=%b fire=%b want 0/1", stall, issue_fire); end
        advance();
    endtask

    task automatic test_alu_forward();
        do_reset();
        drive(1, 0, 0, 2'b00, 1, 3, 1, 0);
        advance();
        drive(1, 3, 0, 2'b01, 1, 4, 1, 0);
        cmp_n++; if (stall !== 1'b0) begin fail_n++; $display("FAIL alu_stall: got %b want 0", stall); end
        cmp_n++; if (fwd_sel[1:0] !== 2'd1) begin fail_n++; $display("FAIL alu_fwd: got %0d want 1", fwd_sel[1:0]); end
        advance();
    endtask

    task automatic test_load_stall();
        do_reset();
        drive(1, 0, 0, 2'b00, 1, 5, 2, 0);
        advance();
        drive(1, 5, 0, 2'b01, 1, 6, 1, 0);
        cmp_n++; if (stall !== 1'b1 || issue_fire !== 1'b0) begin fail_n++; $display("FAIL load_stall: got stall=%b fire=%b want 1/0", stall, issue_fire); end
        advance();
        cmp_n++; if (stall !== 1'b0 || issue_fire !== 1'b1) begin fail_n++; $display("FAIL load_release: got stall=%b fire=%b want 0/1", stall, issue_fire); end
        cmp_n++; if (fwd_sel[1:0] !== 2'd2) begin fail_n++; $display("FAIL load_fwd: got %0d want 2", fwd_sel[1:0]); end
        cmp_n++; if (stall_cnt !== 16'd1) begin fail_n++; $display("FAIL load_cnt: got %0d want 1", stall_cnt); end
        advance();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 2'b00, 1, 5, 2, 0);
        advance();
        drive(1, 5, 0, 2'b01, 1, 6, 1, 1);
        cmp_n++; if (stall !== 1'b0 || issue_fire !== 1'b0) begin fail_n++; $display("FAIL flush_cycle: got stall=%b fire=%b want 0/0", stall, issue_fire); end
        advance();
        drive(1, 6, 5, 2'b11, 0, 0, 1, 0);
        cmp_n++; if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd0) begin fail_n++; $display("FAIL flush_noentry: got stall=%b fwd0=%0d want 0/0", stall, fwd_sel[1:0]); end
        cmp_n++; if (fwd_sel[3:2] !== 2'd2) begin fail_n++; $display("FAIL flush_load_fwd: got %0d want 2", fwd_sel[3:2]); end
        advance();
    endtask

    task automatic test_waw();
        do_reset();
        drive(1, 0, 0, 2'b00, 1, 7, 2, 0);
        advance();
        drive(1, 0, 0, 2'b00, 1, 7, 1, 0);
        advance();
        drive(1, 7, 0, 2'b01, 0, 0, 1, 0);
        cmp_n++; if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd1) begin fail_n++; $display("FAIL waw: got stall=%b fwd0=%0d want 0/1", stall, fwd_sel[1:0]); end
        advance();
    endtask

    task automatic test_r0_and_expiry();
        do_reset();
        drive(1, 0, 0, 2'b11, 1, 0, 2, 0);
        cmp_n++; if (stall !== 1'b0 || fwd_sel !== '0) begin fail_n++; $display("FAIL r0_same: got stall=%b fwd=%h want 0/0", stall, fwd_sel); end
        advance();
        drive(1, 0, 0, 2'b11, 0, 0, 1, 0);
        cmp_n++; if (stall !== 1'b0 || fwd_sel !== '0) begin fail_n++; $display("FAIL r0_next: got stall=%b fwd=%h want 0/0", stall, fwd_sel); end
        advance();
        drive(1, 0, 0, 2'b00, 1, 9, 1, 0);
        advance();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        advance();
        advance();
        drive(1, 9, 0, 2'b01, 0, 0, 1, 0);
        cmp_n++; if (fwd_sel[1:0] !== 2'd3) begin fail_n++; $display("FAIL wb_fwd: got %0d want 3", fwd_sel[1:0]); end
        advance();
        cmp_n++; if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd0) begin fail_n++; $display("FAIL expired: got stall=%b fwd0=%0d want 0/0", stall, fwd_sel[1:0]); end
        advance();
    endtask

    task automatic test_reset_mid_hazard();
        do_reset();
        drive(1, 0, 0, 2'b00, 1, 5, 2, 0);
        advance();
        Resetn = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        advance();
        Resetn = 1'b1;
        drive(1, 5, 0, 2'b01, 0, 0, 1, 0);
        cmp_n++; if (stall !== 1'b0 || issue_fire !== 1'b1) begin fail_n++; $display("FAIL midrst_issue: got stall=%b fire=%b want 0/1", stall, issue_fire); end
        cmp_n++; if (fwd_sel !== '0 || stall_cnt !== 16'd0) begin fail_n++; $display("FAIL midrst_state: got fwd=%h cnt=%0d want 0/0", fwd_sel, stall_cnt); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            Resetn = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), LW'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0);
            model_eval();
            cmp_n++; if (stall !== m_stall || issue_fire !== m_fire) begin fail_n++; $display("FAIL rnd_ctl cyc %0d: got stall=%b fire=%b want %b/%b", cyc, stall, issue_fire, m_stall, m_fire); end
            for (int p = 0; p < NPORT; p++) begin
                cmp_n++; if (fwd_sel[p*LW +: LW] !== m_fwd[p]) begin fail_n++; $display("FAIL rnd_fwd%0d cyc %0d: got %0d want %0d", p, cyc, fwd_sel[p*LW +: LW], m_fwd[p]); end
            end
            cmp_n++; if (int'(stall_cnt) !== scnt) begin fail_n++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", cyc, stall_cnt, scnt); end
            advance();
        end
        Resetn = 1'b1;
    endtask

    initial begin
        model_clear();
        scnt = 0;
        test_reset();
        test_alu_forward();
        test_load_stall();
        test_flush();
        test_waw();
        test_r0_and_expiry();
        test_reset_mid_hazard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter AW, default 5: register-address width; 2**AW architectural registers.
REQ-002 The block SHALL have parameter NPORT, default 2: number of source-operand read ports checked per issuing instruction.
REQ-003 The block SHALL have parameter DEPTH, default 3: pipeline stages after ID (1=EXE, 2=MEM, 3=WB); LW = clog2(DEPTH+1).
REQ-004 The block SHALL have port Clock  in  1: single clock, rising edge.
REQ-005 The block SHALL have port Resetn  in  1: reset, synchronous, active-low.
REQ-006 The block SHALL have port issue_valid  in  1: instruction in ID requests issue.
REQ-007 The block SHALL have port issue_rs  in  NPORT*AW: source register numbers, port p in bits [p*AW +: AW].
REQ-008 The block SHALL have port issue_rs_used  in  NPORT: per-port flag, source actually read.
REQ-009 The block SHALL have port issue_wreg  in  1: instruction writes a register.
REQ-010 The block SHALL have port issue_rn  in  AW: destination register.
REQ-011 The block SHALL have port issue_lat  in  LW: stage index (1..DEPTH) at whose output the result first becomes forwardable (ALU=1, load=2).
REQ-012 The block SHALL have port flush  in  1: kill the instruction currently in ID (taken branch/jump).
REQ-013 The block SHALL have port stall  out  1: hold PC and IF/ID, insert bubble into ID/EXE.
REQ-014 The block SHALL have port issue_fire  out  1: instruction leaves ID this cycle.
REQ-015 The block SHALL have port fwd_sel  out  NPORT*LW: per port, 0 = register file, k = forward from stage-k output.
REQ-016 The block SHALL have port stall_cnt  out  16: saturating count of stall cycles since reset.

Function
REQ-017 The block SHALL keep one entry per register r != 0 holding valid, age (LW bits) and lat (LW bits); register 0 SHALL never be tracked, never stall and always get fwd_sel=0.
REQ-018 Port p SHALL be hazardous when issue_rs_used[p], rs != 0, entry[rs].valid and entry[rs].age < entry[rs].lat.
REQ-019 stall SHALL equal issue_valid AND NOT flush AND (any port hazardous), combinationally in the same cycle.
REQ-020 issue_fire SHALL equal issue_valid AND NOT flush AND NOT stall.
REQ-021 For a non-hazardous port with a valid matching entry, fwd_sel SHALL equal entry.age; otherwise it SHALL be 0.
REQ-022 On each rising edge, every valid entry SHALL increment age; an entry whose age equals DEPTH SHALL clear valid instead.
REQ-023 On issue_fire with issue_wreg=1 and issue_rn != 0, entry[issue_rn] SHALL load valid=1, age=1, lat=issue_lat at the edge; this write SHALL override the increment/clear of REQ-022 (newest producer wins, WAW).
REQ-024 A stalled or flushed instruction SHALL NOT create an entry; in-flight entries SHALL keep ageing during stall (bubbles propagate).
REQ-025 issue_lat values of 0 SHALL be treated as 1; values above DEPTH SHALL be treated as DEPTH.
REQ-026 An instruction that reads and writes the same register SHALL evaluate hazards against the old entry before REQ-023 applies.
REQ-027 stall_cnt SHALL increment on each edge where stall=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-028 While Resetn=0 at a rising edge, all entries SHALL clear (valid=0, age=0, lat=0) and stall_cnt SHALL load 0.
REQ-029 While Resetn=0, stall, issue_fire and fwd_sel SHALL be driven 0; a reset mid-hazard SHALL drop all pending entries with no residual stall after release.

Structure
REQ-030 A shared package hazard_pkg SHALL hold default AW/NPORT/DEPTH, the LW derivation and fwd_sel encoding constants (FWD_RF=0, FWD_EXE=1, FWD_MEM=2, FWD_WB=3).
REQ-031 The per-register age/lat/valid state SHALL be one sub-module, sb_entry, instantiated 2**AW-1 times; hazard compare and fwd mux stay in hazard_scoreboard.

Verification
REQ-032 The bench SHALL issue ALU add r3 (lat=1), then next cycle sub using r3 on port 0 -> stall=0, fwd_sel[0]=1.
REQ-033 The bench SHALL issue load r5 (lat=2), then next cycle consumer of r5 -> one cycle stall=1, issue_fire=0; following cycle stall=0, fwd_sel=2; stall_cnt=1.
REQ-034 The bench SHALL issue load r5, then consumer with flush=1 in the hazard cycle -> stall=0, issue_fire=0, no entry created for consumer's rn.
REQ-035 The bench SHALL issue load r7 then ALU r7 back-to-back, then reader of r7 -> no stall, fwd_sel=1 (newest producer).
REQ-036 The bench SHALL issue a write to r0 and a read of r0 on both ports -> stall=0, fwd_sel=0 always; also read r9 four cycles after its producer (DEPTH=3) -> fwd_sel=0.
REQ-037 The bench SHALL issue load r5 and assert Resetn=0 for one edge before the consumer -> after release consumer fires with stall=0, fwd_sel=0, stall_cnt=0.
